// File: rtl/ifns_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifns_arb_pkg
// Description : Shared widths, codeword type and the Fibonacci weight helper
//               for the IFNS encode arbiter and its encoder core.
// Revision    : 1.0 - initial release
// ============================================================================
package ifns_arb_pkg;

    localparam int IFNS_DATA_W = 20;
    localparam int IFNS_CODE_W = 29;
    localparam int CNT_W       = 16;

    // Codeword is numbered [29:1]; bit 29 is transmitted first.
    typedef logic [IFNS_CODE_W:1] ifns_code_t;

    // Weight of codeword bit k: 1, 2, 3, 5, 8, ... (Fibonacci, no repeated 1).
    // 29 such weights cover every 20-bit value with no two adjacent ones set.
    function automatic int unsigned ifns_weight(input int k);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 2;
        if (k <= 1) begin
            return 1;
        end
        for (int i = 2; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoderIFNS_20di_core.sv
`default_nettype none
// ============================================================================
// Module      : encoderIFNS_20di_core
// Description : Purely combinational 20-bit to 29-bit IFNS encoder. Greedy
//               Fibonacci decomposition from the heaviest weight down, which
//               yields a codeword with no two adjacent ones.
// Revision    : 1.0 - output register moved out to the arbiter
// ============================================================================
module encoderIFNS_20di_core
    import ifns_arb_pkg::*;
(
    input  logic [IFNS_DATA_W-1:0] data_in,
    output ifns_code_t             code_out
);

    // Remainder still to be represented when stage k is evaluated.
    logic [IFNS_DATA_W-1:0] w_rem [1:IFNS_CODE_W];

    assign w_rem[IFNS_CODE_W] = data_in;

    for (genvar k = IFNS_CODE_W; k >= 1; k--) begin : g_stage
        localparam logic [IFNS_DATA_W-1:0] c_weight = IFNS_DATA_W'(ifns_weight(k));

        assign code_out[k] = (w_rem[k] >= c_weight);

        if (k > 1) begin : g_carry
            assign w_rem[k-1] = code_out[k] ? (w_rem[k] - c_weight) : w_rem[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifns_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ifns_rr_arbiter
// Description : Combinational round-robin grant. Picks the first valid
//               requester at or above rr_ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module ifns_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    int              w_sum;
    logic [ID_W-1:0] w_idx;

    // Walk the requesters in priority order starting at the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(rr_ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = ID_W'(w_sum);
            if (!grant_any && req_valid[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                grant_any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifns_encode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ifns_encode_arbiter
// Description : Round-robin scheduler sharing one IFNS encoder core among
//               NUM_REQ requesters. Registers codeword, requester ID and an
//               issue counter; holds the last codeword on the bus when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module ifns_encode_arbiter
    import ifns_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*IFNS_DATA_W-1:0] req_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IFNS_CODE_W:1]           codeout,
    output logic [ID_W-1:0]                out_id,
    output logic [CNT_W-1:0]               enc_count
);

    ifns_code_t             r_codeout;
    logic [ID_W-1:0]        r_out_id;
    logic                   r_out_valid;
    logic [CNT_W-1:0]       r_enc_count;
    logic [ID_W-1:0]        r_rr_ptr;

    logic                   w_load;
    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_grant_any;
    logic [IFNS_DATA_W-1:0] w_sel_data;
    ifns_code_t             w_code;
    logic [ID_W-1:0]        w_next_ptr;

    // Output register is free when empty or being drained this cycle.
    assign w_load = ~r_out_valid | out_ready;

    ifns_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    // Nobody is accepted while reset is held, even though the register is empty.
    assign req_ready = (w_load && !rst) ? w_grant : '0;

    // Route the granted requester's word into the shared encoder.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_data = req_data[i*IFNS_DATA_W +: IFNS_DATA_W];
            end
        end
    end

    encoderIFNS_20di_core u_core (
        .data_in  (w_sel_data),
        .code_out (w_code)
    );

    assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant_idx + 1'b1);

    // Capture a new codeword on transfer; on an idle load only drop valid so the bus holds.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_codeout   <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
            r_enc_count <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_grant_any) begin
                r_codeout   <= w_code;
                r_out_id    <= w_grant_idx;
                r_out_valid <= 1'b1;
                r_rr_ptr    <= w_next_ptr;
                r_enc_count <= r_enc_count + 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign codeout   = r_codeout;
    assign out_id    = r_out_id;
    assign out_valid = r_out_valid;
    assign enc_count = r_enc_count;

endmodule
`default_nettype wire

// File: tb/tb_ifns_encode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifns_encode_arbiter
// Description : Self-checking bench for ifns_encode_arbiter with a
//               transaction-level reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifns_encode_arbiter;

    localparam int NREQ = 4;

    logic          clock;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [79:0]   req_data;
    logic          out_valid;
    logic          out_ready;
    logic [29:1]   codeout;
    logic [1:0]    out_id;
    logic [15:0]   enc_count;

    int vectors;
    int miscompares;

    ifns_encode_arbiter #(.NUM_REQ(NREQ)) dut (
        .clock     (clock),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeout   (codeout),
        .out_id    (out_id),
        .enc_count (enc_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fibonacci weights 1,2,3,5,8,... for codeword bits 1..29.
    function automatic int unsigned fibw(input int k);
        int unsigned a = 1;
        int unsigned b = 2;
        int unsigned t;
        if (k == 1) return 1;
        for (int i = 2; i < k; i++) begin t = a + b; a = b; b = t; end
        return b;
    endfunction

    // Zeckendorf representation of v: largest weight first.
    function automatic logic [29:1] m_ifns(input int unsigned v);
        logic [29:1] c = '0;
        int unsigned r = v;
        for (int k = 29; k >= 1; k--) begin
            if (r >= fibw(k)) begin c[k] = 1'b1; r = r - fibw(k); end
        end
        return c;
    endfunction

    function automatic int unsigned weight_sum(input logic [29:1] c);
        int unsigned s = 0;
        for (int k = 1; k <= 29; k++) if (c[k]) s = s + fibw(k);
        return s;
    endfunction

    // ---------------- reference model ----------------
    logic        m_valid;
    logic [29:1] m_code;
    int          m_id;
    logic [15:0] m_cnt;
    int          m_ptr;
    int unsigned m_data;

    function automatic int m_pick();
        for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r = '0;
        int g = m_pick();
        if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_code  <= '0;
            m_id    <= 0;
            m_cnt   <= '0;
            m_ptr   <= 0;
            m_data  <= 0;
        end else if (!m_valid || out_ready) begin
            if (m_pick() >= 0) begin
                m_valid <= 1'b1;
                m_code  <= m_ifns(int'(req_data[m_pick()*20 +: 20]));
                m_data  <= int'(req_data[m_pick()*20 +: 20]);
                m_id    <= m_pick();
                m_ptr   <= (m_pick() + 1) % NREQ;
                m_cnt   <= m_cnt + 16'd1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle away from the active edge.
    always @(negedge clock) begin
        if (!rst) begin
            chk("req_ready", 32'(req_ready), 32'(m_ready()));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("codeout", 32'(codeout), 32'(m_code));
            chk("out_id", 32'(out_id), 32'(m_id));
            chk("enc_count", 32'(enc_count), 32'(m_cnt));
            if (out_valid) begin
                chk("code_sum", weight_sum(codeout), m_data);
                chk("code_adjacent", 32'(codeout & (codeout >> 1)), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int exp_ids[8] = '{2, 3, 0, 1, 2, 3, 0, 1};
    int exp_alt[4] = '{3, 1, 3, 1};
    int n;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        out_ready   = 1'b1;
        tick();
        // Ready must stay low while reset is held, even with requests pending.
        req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(codeout), 32'd0);
        chk("rst_count", 32'(enc_count), 32'd0);
        req_valid = '0;
        tick();
        rst = 1'b0;

        // Requester 0 sends zero.
        req_valid = 4'b0001;
        req_data[19:0] = 20'h00000;
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_code", 32'(codeout), 32'd0);
        chk("t1_id", 32'(out_id), 32'd0);
        chk("t1_count", 32'(enc_count), 32'd1);
        req_valid = '0;
        tick();
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        chk("t1_idle_code", 32'(codeout), 32'd0);

        // Requester 1 sends 12 = 8+3+1 -> bits 5,3,1.
        req_valid = 4'b0010;
        req_data[39:20] = 20'd12;
        tick();
        chk("t12_code", 32'(codeout), 32'h15);
        chk("t12_id", 32'(out_id), 32'd1);
        req_valid = '0;

        // All four requesters valid; pointer sits at 2.
        req_data  = {20'h80000, 20'h00001, 20'hABCDE, 20'h12345};
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_order", 32'(out_id), 32'(exp_ids[i]));
        end
        req_valid = '0;
        tick();

        // Requester 2 sends all-ones, then downstream stalls for 3 cycles.
        req_data[59:40] = 20'hFFFFF;
        req_valid = 4'b0100;
        tick();
        chk("st_id", 32'(out_id), 32'd2);
        chk("st_count", 32'(enc_count), 32'd11);
        req_data[59:40] = 20'd5;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("st_ready", 32'(req_ready), 32'd0);
            tick();
            chk("st_hold_id", 32'(out_id), 32'd2);
            chk("st_hold_count", 32'(enc_count), 32'd11);
            chk("st_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("st_resume_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("st_resume_code", 32'(codeout), 32'h8);
        chk("st_resume_count", 32'(enc_count), 32'd12);
        req_valid = '0;

        // Requester 1 moves the pointer to 2, then only 1 and 3 compete.
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_order", 32'(out_id), 32'(exp_alt[i]));
        end
        chk("alt_count", 32'(enc_count), 32'd17);
        req_valid = '0;
        tick();

        // Run the counter up to 0xFFFE, then observe the wrap.
        req_data[19:0] = 20'h0ABCD;
        req_valid = 4'b0001;
        n = 32'hFFFE - int'(m_cnt);
        repeat (n) tick();
        tick();
        chk("wrap_ffff", 32'(enc_count), 32'hFFFF);
        tick();
        chk("wrap_0000", 32'(enc_count), 32'h0000);
        tick();
        chk("wrap_0001", 32'(enc_count), 32'h0001);

        // Reset during a stall: immediate clear, pointer back to 0.
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_code", 32'(codeout), 32'd0);
        chk("mid_rst_id", 32'(out_id), 32'd0);
        chk("mid_rst_count", 32'(enc_count), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1001;
        tick();
        chk("post_rst_id", 32'(out_id), 32'd0);
        chk("post_rst_count", 32'(enc_count), 32'd1);
        req_valid = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
